i2cs_pin_conditioner: RTL
=========================

# i2cs_pin_conditioner

Input conditioning stage directly upstream of the I2C peripheral (slave) interface. Synchronizes raw SCL/SDA pins into the APB clock domain, rejects glitches with a programmable debounce filter, applies independent programmable SCL and SDA delays, and emits conditioned bus levels plus START/STOP/SCL-edge pulses. Its length inputs come from the register block's debounce/SCL-delay/SDA-delay fields; its outputs replace the raw pin connections into the peripheral interface.

## Interface
- SYNC_STAGES, 2, synchronizer flops per pin (legal 2..4)
- apb_pclk_i  in  1  system clock; all state on rising edge
- apb_presetn_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  conditioner enable (register block i2c_enabled)
- debounce_len_i  in  8  debounce length; stable-cycle requirement is debounce_len_i+1
- scl_delay_len_i  in  8  extra SCL delay in cycles
- sda_delay_len_i  in  8  extra SDA delay in cycles
- i2c_scl_i  in  1  raw SCL pin, asynchronous
- i2c_sda_i  in  1  raw SDA pin, asynchronous
- scl_o  out  1  conditioned SCL level
- sda_o  out  1  conditioned SDA level
- scl_rise_o  out  1  one-cycle pulse, scl_o 0->1
- scl_fall_o  out  1  one-cycle pulse, scl_o 1->0
- start_o  out  1  one-cycle pulse, START (incl. repeated START)
- stop_o  out  1  one-cycle pulse, STOP
- busy_o  out  1  bus busy: set by START, cleared by STOP

## Operation
- Per pin, identical pipeline: synchronizer -> debounce -> delay. Synchronizer flops reset to 1 (idle bus high).
- Debounce: filtered register F, 8-bit counter C. Synced value == F: C cleared. Differs: C increments; when C == debounce_len_i, F takes synced value and C clears. A reversion before the threshold clears C (glitch discarded, F unchanged).
- Delay: output register O, pending bit P, value V, 8-bit counter D. On F change: V <= new F, D <= 0, P <= 1, delay length latched. While P: D increments; when D == latched length, O <= V, P <= 0. An F change while P set replaces V and restarts D (single pending slot, inertial).
- Length inputs are latched when a count starts; changes mid-count affect only the next count.
- Edge pulses: scl_rise_o/scl_fall_o registered, asserted the cycle after scl_o changes.
- START: sda_o changes 1->0 while scl_o is 1 on both the previous and current cycle. STOP: sda_o changes 0->1 under the same SCL condition. SCL and SDA changing in the same cycle produce neither. Pulses registered, one cycle after the SDA edge.
- busy_o: set on START pulse cycle, cleared on STOP pulse cycle; repeated START keeps it set.
- enable_i low: synchronizers keep running; F, O, V forced to 1; C, D, P cleared; all pulses 0; busy_o 0. On re-enable, a low pin level propagates through the full pipeline latency with no START reported unless SCL-high/SDA-fall occurs after enable.
- Counters never wrap: comparison with the latched length ends the count at most 255.

## Timing
- Reset values: scl_o=1, sda_o=1, all pulses 0, busy_o=0; internal counters 0, P=0.
- Reset assertion takes effect asynchronously mid-operation; deassertion synchronous to apb_pclk_i.
- Latency, first clock edge sampling a new stable pin level counted as 1: output changes on edge SYNC_STAGES + (debounce_len+1) + (delay_len+1). Defaults, lengths 0: edge 4.
- Pulses (start_o, stop_o, scl_rise_o, scl_fall_o): one cycle after the corresponding output change, width exactly one cycle.
- Minimum pin pulse passed: debounce_len+1 synced cycles; shorter pulses fully suppressed.

## Test plan
- Reset/idle: presetn low with pins 0 -> scl_o=sda_o=1, busy_o=0; release with pins 1 -> no pulses for 100 cycles.
- Latency: lengths 0, SYNC_STAGES=2, drop SDA then SCL 20 cycles apart -> sda_o falls at edge 4, start_o one cycle later, busy_o=1; SCL fall gives scl_fall_o.
- Glitch: debounce_len=3, SDA low pulse of 3 cycles -> no change; 4 cycles -> sda_o falls at edge 2+4+1=7.
- Delay skew: scl_delay=10, sda_delay=0, SCL rise then SDA rise 5 cycles later -> scl_o rises after sda_o; no STOP reported; busy_o unchanged.
- STOP/repeated START: START, SCL low/high, SDA 0->1 with SCL high -> stop_o pulse, busy_o=0; SDA 1->0 without STOP -> second start_o, busy_o stays 1.
- Enable/reset mid-count: debounce_len=200, drop enable_i or presetn at count 100 -> outputs 1, busy_o 0, no pulses; after restore, full 201-cycle count required.

Source files
------------

// File: rtl/i2cs_pin_conditioner.sv
// I2C slave pin conditioner: sync -> debounce -> delay per pin, then SCL edge and START/STOP detection.
// Latency SYNC_STAGES+(debounce+1)+(delay+1) to level, +1 to pulses; free-running, no backpressure.
module i2cs_pin_conditioner #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       apb_pclk_i,
  input  logic       apb_presetn_i,
  input  logic       enable_i,
  input  logic [7:0] debounce_len_i,
  input  logic [7:0] scl_delay_len_i,
  input  logic [7:0] sda_delay_len_i,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_rise_o,
  output logic       scl_fall_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  // index 0 = SCL, index 1 = SDA
  logic [1:0]      pin_raw;
  logic [1:0]      pin_out;
  logic [1:0][7:0] dly_len;

  assign pin_raw = {i2c_sda_i, i2c_scl_i};
  assign dly_len = {sda_delay_len_i, scl_delay_len_i};

  for (genvar p = 0; p < 2; p++) begin : g_pin
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   flt_q, flt_d;
    logic [7:0]             cnt_q, cnt_d, dlat_q, dlat_d, db_lim;
    logic                   out_q, out_d, val_q, val_d, pend_q, pend_d;
    logic [7:0]             dcnt_q, dcnt_d, llat_q, llat_d;

    assign synced     = sync_q[SYNC_STAGES-1];
    assign pin_out[p] = out_q;

    // Debounce: the length is sampled on the first differing cycle and held for that count.
    always_comb begin
      flt_d  = flt_q;
      cnt_d  = cnt_q;
      dlat_d = dlat_q;
      db_lim = (cnt_q == 8'd0) ? debounce_len_i : dlat_q;
      if (!enable_i) begin
        flt_d = 1'b1;
        cnt_d = 8'd0;
      end else if (synced == flt_q) begin
        cnt_d = 8'd0;
      end else begin
        if (cnt_q == 8'd0) dlat_d = debounce_len_i;
        if (cnt_q == db_lim) begin
          flt_d = synced;
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    // Inertial delay: a new filtered value restarts the single pending slot.
    always_comb begin
      out_d  = out_q;
      val_d  = val_q;
      pend_d = pend_q;
      dcnt_d = dcnt_q;
      llat_d = llat_q;
      if (!enable_i) begin
        out_d  = 1'b1;
        val_d  = 1'b1;
        pend_d = 1'b0;
        dcnt_d = 8'd0;
      end else if (flt_d != flt_q) begin
        val_d  = flt_d;
        dcnt_d = 8'd0;
        pend_d = 1'b1;
        llat_d = dly_len[p];
      end else if (pend_q) begin
        if (dcnt_q == llat_q) begin
          out_d  = val_q;
          pend_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
    end

    always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
      if (!apb_presetn_i) begin
        sync_q <= '1;
        flt_q  <= 1'b1;
        cnt_q  <= 8'd0;
        dlat_q <= 8'd0;
        out_q  <= 1'b1;
        val_q  <= 1'b1;
        pend_q <= 1'b0;
        dcnt_q <= 8'd0;
        llat_q <= 8'd0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pin_raw[p]};
        flt_q  <= flt_d;
        cnt_q  <= cnt_d;
        dlat_q <= dlat_d;
        out_q  <= out_d;
        val_q  <= val_d;
        pend_q <= pend_d;
        dcnt_q <= dcnt_d;
        llat_q <= llat_d;
      end
    end
  end

  assign scl_o = pin_out[0];
  assign sda_o = pin_out[1];

  logic scl_prev, sda_prev, start_det, stop_det;

  // SCL must be high on both cycles so simultaneous SCL/SDA moves report nothing.
  assign start_det = scl_prev & scl_o & sda_prev & ~sda_o;
  assign stop_det  = scl_prev & scl_o & ~sda_prev & sda_o;

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      scl_prev   <= 1'b1;
      sda_prev   <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else if (!enable_i) begin
      scl_prev   <= 1'b1;
      sda_prev   <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      scl_prev   <= scl_o;
      sda_prev   <= sda_o;
      scl_rise_o <= scl_o & ~scl_prev;
      scl_fall_o <= ~scl_o & scl_prev;
      start_o    <= start_det;
      stop_o     <= stop_det;
      if (start_det)     busy_o <= 1'b1;
      else if (stop_det) busy_o <= 1'b0;
    end
  end

endmodule
